// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and bit-period helper.
// Reused by both the receiver and the matching transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// sync_fifo: first-word fall-through FIFO with a count and pop-bypass on full.
// Ports: clk_i, rst_ni, push_i/data_i, pop_i, data_o, count_o, full_o, empty_o.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push, pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign pop     = pop_i & ~empty_o;
  // A full FIFO still takes a push when the head leaves the same cycle.
  assign push    = push_i & (~full_o | pop);
  assign count_o = cnt_q;
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case (1'b1)
      (push & ~pop): cnt_d = cnt_q + 1'b1;
      (pop & ~push): cnt_d = cnt_q - 1'b1;
      default:       cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with centre sampling, framing check and a byte FIFO.
// Ports: Clk, Reset_N, Uart_Rx in; Rd_Data/Rd_Valid/Rd_Ready pop port;
// Frame_Err and Overrun one-cycle pulses; Fifo_Count occupancy.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          Clk,
  input  logic                          Reset_N,
  input  logic                          Uart_Rx,
  output logic [7:0]                    Rd_Data,
  output logic                          Rd_Valid,
  input  logic                          Rd_Ready,
  output logic                          Frame_Err,
  output logic                          Overrun,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count
);

  localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  logic            sync1_q, sync2_q, rx_s;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            push_req;
  logic            fifo_full, fifo_empty;
  logic            pop;

  assign rx_s = sync2_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    ferr_d   = 1'b0;
    push_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) push_req = 1'b1;
          else      ferr_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop   = Rd_Ready & ~fifo_empty;
  // The byte is lost only if the FIFO is full and nothing leaves this cycle.
  assign ovr_d = push_req & fifo_full & ~pop;

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= Uart_Rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset_N),
    .push_i  (push_req),
    .data_i  (shift_q),
    .pop_i   (Rd_Ready),
    .data_o  (Rd_Data),
    .count_o (Fifo_Count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign Rd_Valid  = ~fifo_empty;
  assign Frame_Err = ferr_q;
  assign Overrun   = ovr_q;

endmodule
